// File: rtl/eject_monitor_mc.sv
// ----------------------------------------------------------------------------
// eject_monitor_mc : N-channel FIFO-buffered eject sink with windowed round-robin drain.
// Optional MONITOR_LOG_EN adds simulation-only flit logging.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef DW
`define DW 32
`endif
`ifndef BUFFER_ALLOC
`define BUFFER_ALLOC 8
`endif
`ifndef BUFFER_ALLOC_LOG
`define BUFFER_ALLOC_LOG 3
`endif

module eject_monitor_mc #(
  parameter int DW        = `DW,
  parameter int CH        = 4,
  parameter int DEPTH     = `BUFFER_ALLOC,
  parameter int DEPTH_LOG = `BUFFER_ALLOC_LOG,
  parameter int PERIOD    = 16,
  parameter int DUTY      = 3,
  parameter int EXPECT    = 1024
`ifdef MONITOR_LOG_EN
  , parameter string LOG_FILE = "receive_pool"
`endif
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [CH-1:0]                      valid_i,
  input  logic [CH*DW-1:0]                   data_i,
  output logic [CH-1:0]                      ready_o,
  output logic [DW-1:0]                      dout_o,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] dout_ch_o,
  output logic                               dout_vld_o,
  output logic [31:0]                        eject_cnt_o,
  output logic                               done_o,
  output logic [CH-1:0]                      err_o
);

  localparam int          CW       = (CH > 1) ? $clog2(CH) : 1;
  localparam int          PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int          CNTW     = DEPTH_LOG + 1;
  localparam logic [31:0] OPEN_AT  = 32'(PERIOD - DUTY);
  localparam logic [31:0] EXPECT_W = 32'(EXPECT);

  logic [CH-1:0]    full;
  logic [CH-1:0]    empty;
  logic [DW-1:0]    head [CH];
  logic [PW-1:0]    phase;
  logic [CW-1:0]    rr;
  logic             win;
  logic             gnt_vld;
  logic [CW-1:0]    gnt_idx;
  logic [31:0]      cnt_inc;
  logic [CH-1:0]    prev_valid;
  logic [CH-1:0]    prev_ready;
  logic [CH*DW-1:0] prev_data;

  assign ready_o = ~full;
  assign win     = (32'(phase) >= OPEN_AT);
  assign cnt_inc = (eject_cnt_o == 32'hFFFF_FFFF) ? eject_cnt_o : eject_cnt_o + 32'd1;

  function automatic logic [DEPTH_LOG-1:0] bump(input logic [DEPTH_LOG-1:0] p);
    return (p == DEPTH_LOG'(DEPTH - 1)) ? '0 : p + DEPTH_LOG'(1);
  endfunction

  generate
    for (genvar c = 0; c < CH; c++) begin : g_fifo
      logic [DW-1:0]        mem [DEPTH];
      logic [DEPTH_LOG-1:0] wr_ptr;
      logic [DEPTH_LOG-1:0] rd_ptr;
      logic [CNTW-1:0]      count;
      logic                 push;
      logic                 pop;

      assign push     = valid_i[c] & ~full[c];
      assign pop      = gnt_vld & (gnt_idx == CW'(c));
      assign full[c]  = (count == CNTW'(DEPTH));
      assign empty[c] = (count == '0);
      assign head[c]  = mem[rd_ptr];

      always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i[c*DW +: DW];
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push) wr_ptr <= bump(wr_ptr);
          if (pop)  rd_ptr <= bump(rd_ptr);
          if (push && !pop)      count <= count + CNTW'(1);
          else if (!push && pop) count <= count - CNTW'(1);
        end
      end
    end
  endgenerate

  // Priority is distance from rr+1 modulo CH; the smallest distance wins.
  always_comb begin
    int d;
    int best;
    best    = CH;
    gnt_idx = rr;
    for (int c = 0; c < CH; c++) begin
      d = (c + 2 * CH - 1 - int'(rr)) % CH;
      if (!empty[c] && d < best) begin
        best    = d;
        gnt_idx = CW'(c);
      end
    end
    gnt_vld = win && (best < CH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase       <= '0;
      rr          <= CW'(CH - 1);
      dout_o      <= '0;
      dout_ch_o   <= '0;
      dout_vld_o  <= 1'b0;
      eject_cnt_o <= '0;
      done_o      <= 1'b0;
    end else begin
      phase      <= (phase == PW'(PERIOD - 1)) ? '0 : phase + PW'(1);
      dout_vld_o <= gnt_vld;
      if (gnt_vld) begin
        dout_o      <= head[gnt_idx];
        dout_ch_o   <= gnt_idx;
        rr          <= gnt_idx;
        eject_cnt_o <= cnt_inc;
        if (cnt_inc >= EXPECT_W) done_o <= 1'b1;
      end
    end
  end

  // A stalled offer (valid & ~ready) must be held unchanged until accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_valid <= '0;
      prev_ready <= '0;
      prev_data  <= '0;
      err_o      <= '0;
    end else begin
      prev_valid <= valid_i;
      prev_ready <= ready_o;
      prev_data  <= data_i;
      for (int c = 0; c < CH; c++) begin
        if (prev_valid[c] && !prev_ready[c] &&
            (!valid_i[c] || (data_i[c*DW +: DW] != prev_data[c*DW +: DW])))
          err_o[c] <= 1'b1;
      end
    end
  end

`ifdef MONITOR_LOG_EN
  always @(posedge clk_i) begin
    if (dout_vld_o) $display("%s: %0d %b", LOG_FILE, dout_ch_o, dout_o);
  end

  always @(posedge done_o) begin
    #25000;
    $stop;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_eject_monitor_mc.sv
// Bench for eject_monitor_mc: queue-based reference model on instance A plus
// table-driven and hand-written sequences on three parameterisations.
`default_nettype none

module tb_eject_monitor_mc;

  localparam int DW = 8, CH = 4, DEPTH = 4, DL = 2;
  localparam int PERIOD = 16, DUTY = 3, EXPECT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  va = '0, vb = '0, vc = '0;
  logic [31:0] da = '0, dbb = '0, dcc = '0;

  logic [3:0] a_ready, b_ready, c_ready, a_err, b_err, c_err;
  logic [7:0] a_dout, b_dout, c_dout;
  logic [1:0] a_ch, b_ch, c_ch;
  logic       a_vld, b_vld, c_vld, a_done, b_done, c_done;
  logic [31:0] a_cnt, b_cnt, c_cnt;

  eject_monitor_mc #(.DW(DW), .CH(CH), .DEPTH(DEPTH), .DEPTH_LOG(DL),
                     .PERIOD(PERIOD), .DUTY(DUTY), .EXPECT(EXPECT)) u_a (
    .clk_i(clk), .rst_i(rst), .valid_i(va), .data_i(da), .ready_o(a_ready),
    .dout_o(a_dout), .dout_ch_o(a_ch), .dout_vld_o(a_vld), .eject_cnt_o(a_cnt),
    .done_o(a_done), .err_o(a_err));

  eject_monitor_mc #(.DW(DW), .CH(CH), .DEPTH(DEPTH), .DEPTH_LOG(DL),
                     .PERIOD(4), .DUTY(4), .EXPECT(1024)) u_b (
    .clk_i(clk), .rst_i(rst), .valid_i(vb), .data_i(dbb), .ready_o(b_ready),
    .dout_o(b_dout), .dout_ch_o(b_ch), .dout_vld_o(b_vld), .eject_cnt_o(b_cnt),
    .done_o(b_done), .err_o(b_err));

  eject_monitor_mc #(.DW(DW), .CH(CH), .DEPTH(DEPTH), .DEPTH_LOG(DL),
                     .PERIOD(4), .DUTY(0), .EXPECT(1024)) u_c (
    .clk_i(clk), .rst_i(rst), .valid_i(vc), .data_i(dcc), .ready_o(c_ready),
    .dout_o(c_dout), .dout_ch_o(c_ch), .dout_vld_o(c_vld), .eject_cnt_o(c_cnt),
    .done_o(c_done), .err_o(c_err));

  int checks = 0;
  int errors = 0;
  int n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: plain queues, a phase integer and a last-grant index.
  logic [7:0]  q [CH][$];
  int          phase_m, rr_m;
  logic        m_vld, m_done;
  logic [7:0]  m_dout;
  logic [1:0]  m_ch;
  logic [31:0] m_cnt;
  logic [3:0]  m_err, pv, pr, acc;
  logic [7:0]  pd [CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      q[c].delete();
      pd[c] = '0;
    end
    phase_m = 0; rr_m = CH - 1;
    m_vld = 0; m_done = 0; m_dout = '0; m_ch = '0; m_cnt = '0;
    m_err = '0; pv = '0; pr = '0; acc = '0;
  endtask

  task automatic model_step();
    logic [3:0] rdy;
    logic [7:0] b;
    for (int c = 0; c < CH; c++) rdy[c] = (q[c].size() < DEPTH);
    for (int c = 0; c < CH; c++) begin
      b = da[c*8 +: 8];
      if (pv[c] && !pr[c] && (!va[c] || b != pd[c])) m_err[c] = 1'b1;
      pd[c] = b;
    end
    pv = va; pr = rdy; acc = va & rdy;
    m_vld = 1'b0;
    if (phase_m >= PERIOD - DUTY) begin
      for (int k = 1; k <= CH; k++) begin
        int idx;
        idx = (rr_m + k) % CH;
        if (!m_vld && q[idx].size() > 0) begin
          m_vld = 1'b1; m_dout = q[idx].pop_front(); m_ch = 2'(idx); rr_m = idx;
        end
      end
    end
    if (m_vld) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (m_cnt >= 32'(EXPECT)) m_done = 1'b1;
    end
    for (int c = 0; c < CH; c++) if (va[c] && rdy[c]) q[c].push_back(da[c*8 +: 8]);
    phase_m = (phase_m + 1) % PERIOD;
  endtask

  task automatic check_model();
    logic [3:0] r;
    for (int c = 0; c < CH; c++) r[c] = (q[c].size() < DEPTH);
    chk("a_ready", 32'(a_ready), 32'(r));
    chk("a_vld",   32'(a_vld),   32'(m_vld));
    chk("a_dout",  32'(a_dout),  32'(m_dout));
    chk("a_ch",    32'(a_ch),    32'(m_ch));
    chk("a_cnt",   a_cnt,        m_cnt);
    chk("a_done",  32'(a_done),  32'(m_done));
    chk("a_err",   32'(a_err),   32'(m_err));
  endtask

  // One clock: model consumes the inputs present before the edge, DUT sampled 1 time unit after.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    n++;
    check_model();
  endtask

  // Called 1 time unit after a rising edge; asserts reset asynchronously.
  task automatic do_reset();
    rst = 1'b1; va = '0; vb = '0; vc = '0;
    model_reset();
    #1;
    chk("rst_ready", 32'(a_ready), 32'hF);
    chk("rst_vld",   32'(a_vld),   32'h0);
    chk("rst_cnt",   a_cnt,        32'h0);
    chk("rst_done",  32'(a_done),  32'h0);
    chk("rst_err",   32'(a_err),   32'h0);
    chk("rst_dout",  32'(a_dout),  32'h0);
    chk("rst_ch",    32'(a_ch),    32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        vld;
    logic [1:0]  ch;
    logic [7:0]  dout;
    logic [31:0] cnt;
  } vec_t;
  vec_t tv [10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [7:0] seq, expseq;

    tv[0] = '{4'hF, 32'h03020100, 1'b0, 2'd0, 8'h00, 32'd0};
    tv[1] = '{4'h0, 32'h0,        1'b1, 2'd0, 8'h00, 32'd1};
    tv[2] = '{4'h0, 32'h0,        1'b1, 2'd1, 8'h01, 32'd2};
    tv[3] = '{4'h0, 32'h0,        1'b1, 2'd2, 8'h02, 32'd3};
    tv[4] = '{4'h0, 32'h0,        1'b1, 2'd3, 8'h03, 32'd4};
    tv[5] = '{4'h0, 32'h0,        1'b0, 2'd3, 8'h03, 32'd4};
    tv[6] = '{4'hA, 32'hA300A100, 1'b0, 2'd3, 8'h03, 32'd4};
    tv[7] = '{4'h0, 32'h0,        1'b1, 2'd1, 8'hA1, 32'd5};
    tv[8] = '{4'h0, 32'h0,        1'b1, 2'd3, 8'hA3, 32'd6};
    tv[9] = '{4'h0, 32'h0,        1'b0, 2'd3, 8'hA3, 32'd6};

    @(posedge clk);
    #1;
    do_reset();

    // Done threshold: 9 flits, done must track the observed eject count.
    va = 4'hF; da = 32'h03020100; cyc();
    da = 32'h07060504; cyc();
    va = 4'h1; da = 32'h00000008; cyc();
    va = 4'h0; da = '0;
    seen = 0;
    for (int i = 0; i < 100 && seen < 9; i++) begin
      cyc();
      if (a_vld) seen++;
      chk("t3_cnt",  a_cnt,       32'(seen));
      chk("t3_done", 32'(a_done), 32'(seen >= 8));
    end
    cyc();
    chk("t3_total", a_cnt,       32'd9);
    chk("t3_done9", 32'(a_done), 32'd1);

    // Always-open window: ordered round-robin eject table on instance B.
    for (int i = 0; i < 10; i++) begin
      vb = tv[i].v; dbb = tv[i].d;
      cyc();
      chk($sformatf("t1_vld[%0d]", i),   32'(b_vld),   32'(tv[i].vld));
      chk($sformatf("t1_ch[%0d]", i),    32'(b_ch),    32'(tv[i].ch));
      chk($sformatf("t1_dout[%0d]", i),  32'(b_dout),  32'(tv[i].dout));
      chk($sformatf("t1_cnt[%0d]", i),   b_cnt,        tv[i].cnt);
      chk($sformatf("t1_ready[%0d]", i), 32'(b_ready), 32'hF);
    end
    vb = '0;

    // Zero duty: instance C never ejects and fills up.
    vc = 4'hF; dcc = 32'h44332211;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t6_vld", 32'(c_vld), 32'h0);
    end
    chk("t6_ready", 32'(c_ready), 32'h0);
    chk("t6_cnt",   c_cnt,        32'h0);
    chk("t6_err",   32'(c_err),   32'h0);
    vc = '0;

    // Continuous stream on ch0 under the 3-of-16 window.
    seq = 8'h40; expseq = 8'h40;
    va = 4'h1; da = 32'(seq);
    for (int i = 0; i < 64; i++) begin
      int np;
      np = n;
      cyc();
      if (np % 16 < 13) chk("t2_closed_vld", 32'(a_vld), 32'h0);
      if (a_vld) begin
        chk("t2_seq", 32'(a_dout), 32'(expseq));
        expseq++;
      end
      if (i >= 32 && np % 16 == 12) chk("t2_full", 32'(a_ready[0]), 32'h0);
      if (acc[0]) begin
        seq++;
        da = 32'(seq);
      end
    end
    for (int i = 0; i < 40 && va[0]; i++) begin
      cyc();
      if (acc[0]) va[0] = 1'b0;
    end
    chk("t2_release", 32'(va[0]), 32'h0);

    // Stalled ch2 changes data: only err[2] may set.
    for (int i = 0; i < 20 && (n % 16) != 0; i++) cyc();
    for (int i = 0; i < 4; i++) begin
      va = 4'h4; da = 32'(8'h10 + 8'(i)) << 16;
      cyc();
    end
    chk("t4_full", 32'(a_ready[2]), 32'h0);
    da = 32'h00140000; cyc();
    chk("t4_err_pre", 32'(a_err), 32'h0);
    da = 32'h00150000; cyc();
    chk("t4_err", 32'(a_err), 32'h4);
    for (int i = 0; i < 40 && va[2]; i++) begin
      cyc();
      if (acc[2]) va[2] = 1'b0;
    end
    chk("t4_err_hold", 32'(a_err), 32'h4);

    // Reset with 5 flits buffered discards them.
    do_reset();
    va = 4'hF; da = 32'h53525150; cyc();
    va = 4'h1; da = 32'h00000054; cyc();
    va = 4'h0; da = '0; cyc();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t5_no_eject", 32'(a_vld), 32'h0);
    end
    chk("t5_cnt", a_cnt, 32'h0);

    // Randomized traffic, mostly protocol-compliant with rare stall violations.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (va[c] && !acc[c]) begin
          if ($urandom_range(0, 99) == 0) da[c*8 +: 8] = 8'($urandom);
        end else begin
          va[c] = 1'($urandom_range(0, 1));
          da[c*8 +: 8] = 8'($urandom);
        end
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
